// File: rtl/br_mask_ctrl.sv
// br_mask_ctrl
//   Branch-tag allocation and resolution controller for the speculative core.
//   It owns a pool of one-hot branch tags and hands the lowest free tag to each
//   speculative branch from ID. For every tag it remembers which tags were
//   already in flight at allocation (the older branches).
//   On a correct resolve it broadcasts a tag clear in the same cycle. On a
//   mispredict it computes the squash set and broadcasts it one cycle later,
//   during a single RECOVER cycle.
//
// Ports
//   clk, rst              : clock (rising edge), asynchronous active-high reset
//   id_br_alloc_req_i     : ID wants a tag for a speculative branch
//   br_alloc_gnt_o        : tag granted this cycle (map-table checkpoint write)
//   br_alloc_tag_o        : lowest-index free tag (one-hot), zero when the pool is full
//   br_stall_o            : ID must hold dispatch
//   br_mask_o             : in-flight tag mask for instructions dispatched now
//   rs_resolve_valid_i    : a branch resolves this cycle
//   rs_resolve_tag_i      : one-hot tag of the resolving branch
//   rs_resolve_mispred_i  : the resolving branch was mispredicted
//   br_clear_valid_o      : correct-prediction clear broadcast
//   br_clear_tag_o        : tag to clear from every mask
//   br_squash_valid_o     : recovery broadcast (registered)
//   br_squash_mask_o      : tags to squash (registered)
//   br_recover_tag_o      : checkpoint tag to restore from (registered)
module br_mask_ctrl #(
  parameter int BR_TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_br_alloc_req_i,
  output logic                br_alloc_gnt_o,
  output logic [BR_TAG_W-1:0] br_alloc_tag_o,
  output logic                br_stall_o,
  output logic [BR_TAG_W-1:0] br_mask_o,
  input  logic                rs_resolve_valid_i,
  input  logic [BR_TAG_W-1:0] rs_resolve_tag_i,
  input  logic                rs_resolve_mispred_i,
  output logic                br_clear_valid_o,
  output logic [BR_TAG_W-1:0] br_clear_tag_o,
  output logic                br_squash_valid_o,
  output logic [BR_TAG_W-1:0] br_squash_mask_o,
  output logic [BR_TAG_W-1:0] br_recover_tag_o
);

  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [BR_TAG_W-1:0] busy_q, busy_d;
  logic [BR_TAG_W-1:0] dep_q [BR_TAG_W];
  logic [BR_TAG_W-1:0] dep_d [BR_TAG_W];
  logic [BR_TAG_W-1:0] sq_mask_q, sq_mask_d;
  logic [BR_TAG_W-1:0] sq_tag_q, sq_tag_d;

  logic                eff_resolve;
  logic                eff_clear;
  logic                eff_mispred;
  logic [BR_TAG_W-1:0] clear_tag;
  logic [BR_TAG_W-1:0] alloc_tag;
  logic [BR_TAG_W-1:0] squash_set;
  logic                any_free;
  logic                gnt;

  // Lowest-index free tag: scanning downward, so the last hit wins.
  always_comb begin
    alloc_tag = '0;
    for (int i = BR_TAG_W - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_tag    = '0;
        alloc_tag[i] = 1'b1;
      end
    end
  end

  // A tag j is younger than the resolving branch when its older-set holds that tag.
  always_comb begin
    squash_set = rs_resolve_tag_i;
    for (int j = 0; j < BR_TAG_W; j++) begin
      if (busy_q[j] && |(dep_q[j] & rs_resolve_tag_i)) begin
        squash_set[j] = 1'b1;
      end
    end
  end

  // Resolve qualification, grant, and next-state computation.
  always_comb begin
    eff_resolve = rs_resolve_valid_i && |(busy_q & rs_resolve_tag_i);
    eff_clear   = eff_resolve && !rs_resolve_mispred_i;
    eff_mispred = eff_resolve && rs_resolve_mispred_i;
    clear_tag   = eff_clear ? rs_resolve_tag_i : '0;
    any_free    = |(~busy_q);
    // The ID branch is younger than a mispredicting branch, so it must not get a tag.
    gnt         = id_br_alloc_req_i && any_free && (state_q == NORMAL) && !eff_mispred;

    busy_d    = busy_q & ~clear_tag;
    sq_mask_d = sq_mask_q;
    sq_tag_d  = sq_tag_q;
    state_d   = NORMAL;

    if (eff_mispred) begin
      busy_d    = busy_q & ~squash_set;
      sq_mask_d = squash_set;
      sq_tag_d  = rs_resolve_tag_i;
      state_d   = RECOVER;
    end

    if (gnt) begin
      busy_d = busy_d | alloc_tag;
    end

    // The new branch's older-set excludes a tag that is being cleared right now.
    for (int i = 0; i < BR_TAG_W; i++) begin
      dep_d[i] = dep_q[i] & ~clear_tag;
      if (gnt && alloc_tag[i]) begin
        dep_d[i] = busy_q & ~clear_tag;
      end
    end
  end

  always_comb begin
    br_alloc_gnt_o    = gnt;
    br_alloc_tag_o    = alloc_tag;
    br_stall_o        = (id_br_alloc_req_i && !any_free) || (state_q == RECOVER) || eff_mispred;
    br_mask_o         = busy_q & ~clear_tag;
    br_clear_valid_o  = eff_clear;
    br_clear_tag_o    = clear_tag;
    br_squash_valid_o = (state_q == RECOVER);
    br_squash_mask_o  = sq_mask_q;
    br_recover_tag_o  = sq_tag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= NORMAL;
      busy_q    <= '0;
      sq_mask_q <= '0;
      sq_tag_q  <= '0;
      for (int i = 0; i < BR_TAG_W; i++) begin
        dep_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      sq_mask_q <= sq_mask_d;
      sq_tag_q  <= sq_tag_d;
      for (int i = 0; i < BR_TAG_W; i++) begin
        dep_q[i] <= dep_d[i];
      end
    end
  end

endmodule

// File: tb/tb_br_mask_ctrl.sv
// tb_br_mask_ctrl
//   Cycle-by-cycle vector bench for br_mask_ctrl with BR_TAG_W = 4. Each record
//   holds the inputs for one cycle and the outputs expected in that same cycle.
//   Records are pushed to a scoreboard queue when driven and popped when the
//   outputs are sampled mid-cycle.
module tb_br_mask_ctrl;

  localparam int W = 4;

  typedef struct {
    logic         req;
    logic         rv;
    logic [W-1:0] rtag;
    logic         mis;
    logic         gnt;
    logic [W-1:0] atag;
    logic         stall;
    logic [W-1:0] mask;
    logic         cv;
    logic [W-1:0] ctag;
    logic         sv;
    logic [W-1:0] smask;
    logic [W-1:0] rec;
    logic         chk_sq;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         id_br_alloc_req_i;
  logic         br_alloc_gnt_o;
  logic [W-1:0] br_alloc_tag_o;
  logic         br_stall_o;
  logic [W-1:0] br_mask_o;
  logic         rs_resolve_valid_i;
  logic [W-1:0] rs_resolve_tag_i;
  logic         rs_resolve_mispred_i;
  logic         br_clear_valid_o;
  logic [W-1:0] br_clear_tag_o;
  logic         br_squash_valid_o;
  logic [W-1:0] br_squash_mask_o;
  logic [W-1:0] br_recover_tag_o;

  int   pass_cnt;
  int   total_cnt;
  vec_t tbl[$];
  vec_t exp_q[$];

  br_mask_ctrl #(.BR_TAG_W(W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .id_br_alloc_req_i    (id_br_alloc_req_i),
    .br_alloc_gnt_o       (br_alloc_gnt_o),
    .br_alloc_tag_o       (br_alloc_tag_o),
    .br_stall_o           (br_stall_o),
    .br_mask_o            (br_mask_o),
    .rs_resolve_valid_i   (rs_resolve_valid_i),
    .rs_resolve_tag_i     (rs_resolve_tag_i),
    .rs_resolve_mispred_i (rs_resolve_mispred_i),
    .br_clear_valid_o     (br_clear_valid_o),
    .br_clear_tag_o       (br_clear_tag_o),
    .br_squash_valid_o    (br_squash_valid_o),
    .br_squash_mask_o     (br_squash_mask_o),
    .br_recover_tag_o     (br_recover_tag_o)
  );

  // 10-unit clock; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Resolve tags must be one-hot whenever a resolve is presented.
  always @(posedge clk) begin
    if (!rst && rs_resolve_valid_i) begin
      assert ($onehot(rs_resolve_tag_i))
        else $error("[TB] illegal multi-hot resolve tag %b", rs_resolve_tag_i);
    end
  end

  // Hard upper bound on run time so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(
    logic req, logic rv, logic [W-1:0] rtag, logic mis,
    logic gnt, logic [W-1:0] atag, logic stall, logic [W-1:0] mask,
    logic cv, logic [W-1:0] ctag, logic sv, logic [W-1:0] smask,
    logic [W-1:0] rec, logic chk_sq);
    vec_t v;
    v.req = req;   v.rv = rv;       v.rtag = rtag;   v.mis = mis;
    v.gnt = gnt;   v.atag = atag;   v.stall = stall; v.mask = mask;
    v.cv = cv;     v.ctag = ctag;   v.sv = sv;       v.smask = smask;
    v.rec = rec;   v.chk_sq = chk_sq;
    return v;
  endfunction

  task automatic checkField(input string name, input int idx,
                            input logic [W-1:0] got, input logic [W-1:0] want);
    total_cnt++;
    if (got !== want) begin
      $display("[TB] FAIL %s vec %0d: got %b, want %b", name, idx, got, want);
    end else begin
      pass_cnt++;
    end
  endtask

  // Drive one cycle of inputs and queue its expected outputs.
  task automatic applyStimulus(input vec_t v);
    id_br_alloc_req_i    = v.req;
    rs_resolve_valid_i   = v.rv;
    rs_resolve_tag_i     = v.rtag;
    rs_resolve_mispred_i = v.mis;
    exp_q.push_back(v);
  endtask

  // Pop the oldest expectation and compare it with the current outputs.
  task automatic checkOutput(input int idx);
    vec_t e;
    if (exp_q.size() == 0) begin
      total_cnt++;
      $display("[TB] FAIL scoreboard vec %0d: got empty queue, want one entry", idx);
      return;
    end
    e = exp_q.pop_front();
    checkField("gnt",       idx, {3'b000, br_alloc_gnt_o},    {3'b000, e.gnt});
    checkField("alloc_tag", idx, br_alloc_tag_o,              e.atag);
    checkField("stall",     idx, {3'b000, br_stall_o},        {3'b000, e.stall});
    checkField("mask",      idx, br_mask_o,                   e.mask);
    checkField("clear_v",   idx, {3'b000, br_clear_valid_o},  {3'b000, e.cv});
    checkField("clear_tag", idx, br_clear_tag_o,              e.ctag);
    checkField("squash_v",  idx, {3'b000, br_squash_valid_o}, {3'b000, e.sv});
    if (e.sv || e.chk_sq) begin
      checkField("squash_mask", idx, br_squash_mask_o, e.smask);
      checkField("recover_tag", idx, br_recover_tag_o, e.rec);
    end
  endtask

  initial begin
    vec_t rst_vec;
    vec_t idle;
    pass_cnt  = 0;
    total_cnt = 0;

    // Outputs while reset is held (alloc tag shows the lowest free tag).
    rst_vec = mk(0,0,4'b0000,0, 0,4'b0001,0,4'b0000, 0,4'b0000,0,4'b0000,4'b0000,1);
    idle    = mk(0,0,4'b0000,0, 0,4'b0001,0,4'b0000, 0,4'b0000,0,4'b0000,4'b0000,0);

    //          req rv rtag    mis gnt atag    stl mask    cv ctag    sv smask   rec     chk
    // Fill the pool, then overflow request.
    tbl.push_back(mk(1,0,4'b0000,0, 1,4'b0001,0,4'b0000, 0,4'b0000,0,4'b0000,4'b0000,0)); // 0
    tbl.push_back(mk(1,0,4'b0000,0, 1,4'b0010,0,4'b0001, 0,4'b0000,0,4'b0000,4'b0000,0)); // 1
    tbl.push_back(mk(1,0,4'b0000,0, 1,4'b0100,0,4'b0011, 0,4'b0000,0,4'b0000,4'b0000,0)); // 2
    tbl.push_back(mk(1,0,4'b0000,0, 1,4'b1000,0,4'b0111, 0,4'b0000,0,4'b0000,4'b0000,0)); // 3
    tbl.push_back(mk(1,0,4'b0000,0, 0,4'b0000,1,4'b1111, 0,4'b0000,0,4'b0000,4'b0000,0)); // 4
    // Correct resolve of 0010 while full: clear now, no same-cycle regrant.
    tbl.push_back(mk(1,1,4'b0010,0, 0,4'b0000,1,4'b1101, 1,4'b0010,0,4'b0000,4'b0000,0)); // 5
    tbl.push_back(mk(1,0,4'b0000,0, 1,4'b0010,0,4'b1101, 0,4'b0000,0,4'b0000,4'b0000,0)); // 6
    // Mispredict oldest with a request pending: everything younger squashed.
    tbl.push_back(mk(1,1,4'b0001,1, 0,4'b0000,1,4'b1111, 0,4'b0000,0,4'b0000,4'b0000,0)); // 7
    tbl.push_back(mk(1,0,4'b0000,0, 0,4'b0001,1,4'b0000, 0,4'b0000,1,4'b1111,4'b0001,0)); // 8
    // Three branches, mispredict the middle one.
    tbl.push_back(mk(1,0,4'b0000,0, 1,4'b0001,0,4'b0000, 0,4'b0000,0,4'b0000,4'b0000,0)); // 9
    tbl.push_back(mk(1,0,4'b0000,0, 1,4'b0010,0,4'b0001, 0,4'b0000,0,4'b0000,4'b0000,0)); // 10
    tbl.push_back(mk(1,0,4'b0000,0, 1,4'b0100,0,4'b0011, 0,4'b0000,0,4'b0000,4'b0000,0)); // 11
    tbl.push_back(mk(0,1,4'b0010,1, 0,4'b1000,1,4'b0111, 0,4'b0000,0,4'b0000,4'b0000,0)); // 12
    tbl.push_back(mk(0,0,4'b0000,0, 0,4'b0010,1,4'b0001, 0,4'b0000,1,4'b0110,4'b0010,0)); // 13
    tbl.push_back(mk(0,0,4'b0000,0, 0,4'b0010,0,4'b0001, 0,4'b0000,0,4'b0000,4'b0000,0)); // 14
    // Correct resolve and grant together: new older-set must drop the cleared tag.
    tbl.push_back(mk(1,1,4'b0001,0, 1,4'b0010,0,4'b0000, 1,4'b0001,0,4'b0000,4'b0000,0)); // 15
    tbl.push_back(mk(1,0,4'b0000,0, 1,4'b0001,0,4'b0010, 0,4'b0000,0,4'b0000,4'b0000,0)); // 16
    tbl.push_back(mk(0,1,4'b0001,1, 0,4'b0100,1,4'b0011, 0,4'b0000,0,4'b0000,4'b0000,0)); // 17
    // Second mispredict during RECOVER stays in RECOVER with new data.
    tbl.push_back(mk(0,1,4'b0010,1, 0,4'b0001,1,4'b0010, 0,4'b0000,1,4'b0001,4'b0001,0)); // 18
    tbl.push_back(mk(1,0,4'b0000,0, 0,4'b0001,1,4'b0000, 0,4'b0000,1,4'b0010,4'b0010,0)); // 19
    // Resolves of non-busy tags are ignored.
    tbl.push_back(mk(0,1,4'b0100,0, 0,4'b0001,0,4'b0000, 0,4'b0000,0,4'b0000,4'b0000,0)); // 20
    tbl.push_back(mk(0,1,4'b1000,1, 0,4'b0001,0,4'b0000, 0,4'b0000,0,4'b0000,4'b0000,0)); // 21
    tbl.push_back(mk(0,0,4'b0000,0, 0,4'b0001,0,4'b0000, 0,4'b0000,0,4'b0000,4'b0000,0)); // 22

    rst = 1'b1;
    applyStimulus(rst_vec);
    #2;
    checkOutput(100);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      applyStimulus(tbl[i]);
      #2;
      checkOutput(i);
    end

    // Asynchronous reset in the middle of RECOVER.
    @(negedge clk);
    applyStimulus(mk(1,0,4'b0000,0, 1,4'b0001,0,4'b0000, 0,4'b0000,0,4'b0000,4'b0000,0));
    #2;
    checkOutput(200);
    @(negedge clk);
    applyStimulus(mk(0,1,4'b0001,1, 0,4'b0010,1,4'b0001, 0,4'b0000,0,4'b0000,4'b0000,0));
    #2;
    checkOutput(201);
    @(negedge clk);
    applyStimulus(mk(0,0,4'b0000,0, 0,4'b0001,1,4'b0000, 0,4'b0000,1,4'b0001,4'b0001,0));
    #2;
    checkOutput(202);
    #1;
    rst = 1'b1;
    applyStimulus(rst_vec);
    #1;
    checkOutput(203);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(idle);
    #2;
    checkOutput(204);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
